// File: rtl/correlator_accum_bank.sv
// Early/prompt/late correlator accumulators with coherent integration over several
// code epochs, saturating sums and a double-buffered valid/ready readout.
module correlator_accum_bank #(
    parameter int NUM_TAPS = 3,
    parameter int MAG_W    = 3,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 5,
    parameter int IDX_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic                    mix_i_sign,
    input  logic [MAG_W-1:0]        mix_i_mag,
    input  logic                    mix_q_sign,
    input  logic [MAG_W-1:0]        mix_q_mag,
    input  logic [NUM_TAPS-1:0]     code,
    input  logic                    dump,
    input  logic [CNT_W-1:0]        coh_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [IDX_W-1:0]        out_tap,
    output logic                    out_is_q,
    output logic                    out_last,
    output logic                    out_sat,
    output logic                    overrun,
    input  logic                    overrun_clr
);
    localparam int NWORDS = 2 * NUM_TAPS;
    localparam int WI_W   = IDX_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic signed [ACC_W-1:0] sat_fn(input logic signed [ACC_W:0] x);
        if (x[ACC_W] != x[ACC_W-1])
            return x[ACC_W] ? ACC_MIN : ACC_MAX;
        return x[ACC_W-1:0];
    endfunction

    function automatic logic ovf_fn(input logic signed [ACC_W:0] x);
        return x[ACC_W] ^ x[ACC_W-1];
    endfunction

    logic signed [MAG_W:0]   w_v_i, w_v_q;
    logic signed [MAG_W:0]   w_p_i [NUM_TAPS];
    logic signed [MAG_W:0]   w_p_q [NUM_TAPS];
    logic signed [ACC_W:0]   w_wide_i [NUM_TAPS];
    logic signed [ACC_W:0]   w_wide_q [NUM_TAPS];
    logic signed [ACC_W-1:0] w_sum_i [NUM_TAPS];
    logic signed [ACC_W-1:0] w_sum_q [NUM_TAPS];
    logic signed [ACC_W-1:0] r_acc_i [NUM_TAPS];
    logic signed [ACC_W-1:0] r_acc_q [NUM_TAPS];
    logic signed [ACC_W-1:0] r_shadow_i [NUM_TAPS];
    logic signed [ACC_W-1:0] r_shadow_q [NUM_TAPS];
    logic                    w_ovf;
    logic                    r_sat, r_shadow_sat;
    logic [CNT_W-1:0]        r_dump_cnt, r_coh_len_q;
    logic                    w_complete;
    state_t                  r_state, w_state_nxt;
    logic [WI_W-1:0]         r_idx, w_idx_nxt;
    logic                    w_accept, w_last, w_ovr_set;
    logic [IDX_W-1:0]        w_tap;

    // Stage: signed sample, per-tap code wipe-off and saturating sum
    always_comb begin
        w_v_i = mix_i_sign ? -$signed({1'b0, mix_i_mag}) : $signed({1'b0, mix_i_mag});
        w_v_q = mix_q_sign ? -$signed({1'b0, mix_q_mag}) : $signed({1'b0, mix_q_mag});
        w_ovf = 1'b0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_p_i[k]    = code[k] ? -w_v_i : w_v_i;
            w_p_q[k]    = code[k] ? -w_v_q : w_v_q;
            w_wide_i[k] = {r_acc_i[k][ACC_W-1], r_acc_i[k]}
                        + {{(ACC_W-MAG_W){w_p_i[k][MAG_W]}}, w_p_i[k]};
            w_wide_q[k] = {r_acc_q[k][ACC_W-1], r_acc_q[k]}
                        + {{(ACC_W-MAG_W){w_p_q[k][MAG_W]}}, w_p_q[k]};
            w_sum_i[k]  = r_acc_i[k];
            w_sum_q[k]  = r_acc_q[k];
            if (sample_en) begin
                w_sum_i[k] = sat_fn(w_wide_i[k]);
                w_sum_q[k] = sat_fn(w_wide_q[k]);
                w_ovf      = w_ovf | ovf_fn(w_wide_i[k]) | ovf_fn(w_wide_q[k]);
            end
        end
    end

    // A same-cycle sample is already folded into w_sum, so it lands in the ending epoch
    assign w_complete = dump && (r_dump_cnt == r_coh_len_q);

    // Stage: accumulator bank and shadow (double buffer) registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_acc_i[k]    <= '0;
                r_acc_q[k]    <= '0;
                r_shadow_i[k] <= '0;
                r_shadow_q[k] <= '0;
            end
            r_sat        <= 1'b0;
            r_shadow_sat <= 1'b0;
            r_dump_cnt   <= '0;
            r_coh_len_q  <= coh_len;
        end else if (w_complete) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow_i[k] <= w_sum_i[k];
                r_shadow_q[k] <= w_sum_q[k];
                r_acc_i[k]    <= '0;
                r_acc_q[k]    <= '0;
            end
            r_shadow_sat <= r_sat | w_ovf;
            r_sat        <= 1'b0;
            r_dump_cnt   <= '0;
            r_coh_len_q  <= coh_len;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_acc_i[k] <= w_sum_i[k];
                r_acc_q[k] <= w_sum_q[k];
            end
            r_sat <= r_sat | w_ovf;
            if (dump)
                r_dump_cnt <= r_dump_cnt + CNT_W'(1);
        end
    end

    assign w_accept = (r_state == STREAM) && out_ready;
    assign w_last   = (r_idx == WI_W'(NWORDS - 1));

    // Stage: readout sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_complete) begin
                    w_state_nxt = STREAM;
                    w_idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (w_complete) begin
                    // Completion on the final acceptance chains blocks without a gap
                    w_idx_nxt = '0;
                    w_ovr_set = !(w_accept && w_last);
                end else if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + WI_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            overrun   <= w_ovr_set | (overrun & ~overrun_clr);
        end
    end

    assign w_tap = r_idx[WI_W-1:1];

    always_comb begin
        out_data = '0;
        if (r_state == STREAM) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (w_tap == IDX_W'(k))
                    out_data = r_idx[0] ? r_shadow_q[k] : r_shadow_i[k];
            end
        end
    end

    assign out_valid = (r_state == STREAM);
    assign out_tap   = w_tap;
    assign out_is_q  = r_idx[0];
    assign out_last  = out_valid && w_last;
    assign out_sat   = out_valid && r_shadow_sat;

endmodule

// File: tb/tb_correlator_accum_bank.sv
// Bench for correlator_accum_bank: directed scenarios plus randomized integrations
// checked against an integer model of the accumulate/dump/readout rules.
module tb_correlator_accum_bank;
    localparam int NT = 3, MW = 3, AW = 16, AW8 = 8, CW = 5, IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sample_en, mix_i_sign, mix_q_sign, dump, out_ready, overrun_clr;
    logic [MW-1:0] mix_i_mag, mix_q_mag;
    logic [NT-1:0] code;
    logic [CW-1:0] coh_len;
    logic out_valid, out_is_q, out_last, out_sat, overrun;
    logic signed [AW-1:0] out_data;
    logic [IW-1:0] out_tap;
    logic v8, q8, l8, s8, o8;
    logic signed [AW8-1:0] d8;
    logic [IW-1:0] t8;

    correlator_accum_bank #(.NUM_TAPS(NT), .MAG_W(MW), .ACC_W(AW), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .mix_i_sign(mix_i_sign),
        .mix_i_mag(mix_i_mag), .mix_q_sign(mix_q_sign), .mix_q_mag(mix_q_mag),
        .code(code), .dump(dump), .coh_len(coh_len), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tap(out_tap),
        .out_is_q(out_is_q), .out_last(out_last), .out_sat(out_sat),
        .overrun(overrun), .overrun_clr(overrun_clr));

    correlator_accum_bank #(.NUM_TAPS(NT), .MAG_W(MW), .ACC_W(AW8), .CNT_W(CW), .IDX_W(IW)) dut8 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .mix_i_sign(mix_i_sign),
        .mix_i_mag(mix_i_mag), .mix_q_sign(mix_q_sign), .mix_q_mag(mix_q_mag),
        .code(code), .dump(dump), .coh_len(coh_len), .out_valid(v8),
        .out_ready(out_ready), .out_data(d8), .out_tap(t8),
        .out_is_q(q8), .out_last(l8), .out_sat(s8),
        .overrun(o8), .overrun_clr(overrun_clr));

    // Model: [instance][0=I,1=Q][tap]; instance 0 is 16-bit, 1 is 8-bit
    int m_acc [2][2][NT];
    bit m_sat [2];
    int m_cnt, m_cohq;
    bit m_done;
    int e_blk [2][2*NT];
    bit e_sat [2];
    int n_checks = 0;
    int n_fail = 0;

    task automatic model_clear();
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < NT; k++) m_acc[n][c][k] = 0;
            m_sat[n] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_edge(input bit se, input int vi, input int vq, input bit dp);
        m_done = 1'b0;
        for (int n = 0; n < 2; n++) begin
            int w  = (n == 0) ? AW : AW8;
            int hi = (1 << (w - 1)) - 1;
            int lo = -(1 << (w - 1));
            if (se) begin
                for (int k = 0; k < NT; k++) begin
                    for (int c = 0; c < 2; c++) begin
                        int s = (c == 0) ? vi : vq;
                        int t;
                        if (code[k]) s = -s;
                        t = m_acc[n][c][k] + s;
                        if (t > hi) begin t = hi; m_sat[n] = 1'b1; end
                        if (t < lo) begin t = lo; m_sat[n] = 1'b1; end
                        m_acc[n][c][k] = t;
                    end
                end
            end
        end
        if (dp) begin
            if (m_cnt == m_cohq) begin
                for (int n = 0; n < 2; n++) begin
                    for (int k = 0; k < NT; k++) begin
                        e_blk[n][2*k]   = m_acc[n][0][k];
                        e_blk[n][2*k+1] = m_acc[n][1][k];
                    end
                    e_sat[n] = m_sat[n];
                end
                model_clear();
                m_cohq = int'(coh_len);
                m_done = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle(input bit se, input int vi, input int vq, input bit dp);
        sample_en  = se;
        mix_i_sign = (vi < 0);
        mix_i_mag  = MW'(vi < 0 ? -vi : vi);
        mix_q_sign = (vq < 0);
        mix_q_mag  = MW'(vq < 0 ? -vq : vq);
        dump       = dp;
        @(posedge clk);
        model_edge(se, vi, vq, dp);
        #1;
        sample_en = 1'b0;
        dump      = 1'b0;
    endtask

    function automatic int rnd_val();
        return int'($urandom_range(0, 14)) - 7;
    endfunction

    task automatic do_reset();
        rst = 1'b1; sample_en = 1'b0; dump = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        m_cohq = int'(coh_len);
    endtask

    task automatic drain_stream(input string nm, input int max_stall);
        for (int w = 0; w < 2*NT; w++) begin
            int st = int'($urandom_range(0, max_stall));
            for (int s = 0; s <= st; s++) begin
                out_ready = (s == st);
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== e_blk[0][w] || out_tap !== IW'(w >> 1) ||
                    out_is_q !== w[0] || out_last !== (w == 2*NT-1) || out_sat !== e_sat[0]) begin
                    n_fail++;
                    $display("FAIL %s word %0d: valid=%b data=%0d tap=%0d q=%b last=%b sat=%b; want valid=1 data=%0d tap=%0d q=%b last=%b sat=%b",
                             nm, w, out_valid, out_data, out_tap, out_is_q, out_last, out_sat,
                             e_blk[0][w], w >> 1, w[0], (w == 2*NT-1), e_sat[0]);
                end
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_of_stream: out_valid=%b want 0", nm, out_valid);
        end
    endtask

    task automatic test_reset();
        coh_len = '0; code = '0;
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_sat !== 1'b0 || overrun !== 1'b0 ||
            out_data !== 0 || out_tap !== 0 || v8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b last=%b sat=%b ovr=%b data=%0d tap=%0d v8=%b want all 0",
                     out_valid, out_last, out_sat, overrun, out_data, out_tap, v8);
        end
    endtask

    task automatic test_basic();
        int exp_w [6] = '{30, -10, -30, 10, 30, -10};
        coh_len = '0; code = 3'b010;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 3, -1, i == 9);
        for (int w = 0; w < 6; w++) begin
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[w] || out_last !== (w == 5) || out_sat !== 1'b0) begin
                n_fail++;
                $display("FAIL basic word %0d: valid=%b data=%0d last=%b sat=%b; want 1 %0d %b 0",
                         w, out_valid, out_data, out_last, out_sat, exp_w[w], (w == 5));
            end
            cycle(1'b0, 0, 0, 1'b0);
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic idle_after: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        int vals [3] = '{7, -7, 7};
        int lens [3] = '{50, 50, 5};
        int exp8 [3] = '{127, -128, 35};
        bit exps [3] = '{1'b1, 1'b1, 1'b0};
        coh_len = '0; code = '0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < lens[r]; i++) cycle(1'b1, vals[r], 0, i == lens[r] - 1);
            n_checks++;
            if (v8 !== 1'b1 || d8 !== exp8[r] || s8 !== exps[r] || t8 !== 0 || q8 !== 1'b0 ||
                l8 !== 1'b0 || o8 !== 1'b0) begin
                n_fail++;
                $display("FAIL sat8 round %0d: valid=%b data=%0d sat=%b tap=%0d q=%b last=%b ovr=%b; want 1 %0d %b 0 0 0 0",
                         r, v8, d8, s8, t8, q8, l8, o8, exp8[r], exps[r]);
            end
            n_checks++;
            if (out_data !== vals[r] * lens[r] || out_sat !== 1'b0) begin
                n_fail++;
                $display("FAIL sat16 round %0d: data=%0d sat=%b want %0d 0",
                         r, out_data, out_sat, vals[r] * lens[r]);
            end
            drain_stream("saturation", 1);
            n_checks++;
            if (v8 !== 1'b0) begin
                n_fail++;
                $display("FAIL sat8 drained round %0d: valid=%b want 0", r, v8);
            end
        end
    endtask

    task automatic test_coherent();
        coh_len = 5'd2; code = '0;
        do_reset();
        for (int e = 0; e < 3; e++) begin
            if (e == 2) coh_len = '0;
            for (int i = 0; i < 5; i++) cycle(1'b1, 1, 0, i == 4);
            if (e < 2) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL coherent early dump %0d: out_valid=%b want 0", e + 1, out_valid);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 15) begin
            n_fail++;
            $display("FAIL coherent final: valid=%b data=%0d want 1 15", out_valid, out_data);
        end
        drain_stream("coherent", 2);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1, 0, i == 1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 2) begin
            n_fail++;
            $display("FAIL coherent new_len: valid=%b data=%0d want 1 2", out_valid, out_data);
        end
        drain_stream("coherent_len0", 1);
    endtask

    task automatic test_overrun();
        logic signed [AW-1:0] held;
        coh_len = '0;
        do_reset();
        code = NT'($urandom);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd_val(), rnd_val(), i == 3);
        n_checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun first: valid=%b ovr=%b want 1 0", out_valid, overrun);
        end
        cycle(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_val(), rnd_val(), i == 2);
        n_checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_tap !== 0 || out_is_q !== 1'b0 ||
            out_data !== e_blk[0][0]) begin
            n_fail++;
            $display("FAIL overrun second: ovr=%b valid=%b tap=%0d q=%b data=%0d want 1 1 0 0 %0d",
                     overrun, out_valid, out_tap, out_is_q, out_data, e_blk[0][0]);
        end
        held = out_data;
        cycle(1'b0, 0, 0, 1'b0);
        n_checks++;
        if (out_data !== held || out_tap !== 0) begin
            n_fail++;
            $display("FAIL overrun hold: data=%0d tap=%0d want %0d 0", out_data, out_tap, held);
        end
        overrun_clr = 1'b1;
        cycle(1'b0, 0, 0, 1'b0);
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun clear: ovr=%b want 0", overrun);
        end
        for (int i = 0; i < 3; i++) begin
            overrun_clr = (i == 2);
            cycle(1'b1, rnd_val(), rnd_val(), i == 2);
        end
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun set_wins: ovr=%b want 1", overrun);
        end
        overrun_clr = 1'b1;
        cycle(1'b0, 0, 0, 1'b0);
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun clear2: ovr=%b want 0", overrun);
        end
        drain_stream("overrun", 2);
    endtask

    task automatic test_back_to_back();
        coh_len = '0;
        code = NT'($urandom);
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_val(), rnd_val(), i == 2);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd_val(), rnd_val(), 1'b0);
        for (int w = 0; w < 2*NT-1; w++) begin
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e_blk[0][w] || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b word %0d: valid=%b data=%0d last=%b want 1 %0d 0",
                         w, out_valid, out_data, out_last, e_blk[0][w]);
            end
            cycle(1'b0, 0, 0, 1'b0);
        end
        n_checks++;
        if (out_last !== 1'b1 || out_data !== e_blk[0][2*NT-1]) begin
            n_fail++;
            $display("FAIL b2b last word: last=%b data=%0d want 1 %0d", out_last, out_data, e_blk[0][2*NT-1]);
        end
        out_ready = 1'b1;
        cycle(1'b1, rnd_val(), rnd_val(), 1'b1);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tap !== 0 || out_is_q !== 1'b0 || overrun !== 1'b0 ||
            out_data !== e_blk[0][0]) begin
            n_fail++;
            $display("FAIL b2b chained: valid=%b tap=%0d q=%b ovr=%b data=%0d want 1 0 0 0 %0d",
                     out_valid, out_tap, out_is_q, overrun, out_data, e_blk[0][0]);
        end
        drain_stream("back_to_back", 2);
    endtask

    task automatic test_reset_midstream();
        coh_len = '0;
        code = NT'($urandom);
        for (int i = 0; i < 4; i++) cycle(1'b1, rnd_val(), rnd_val(), i == 3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_val(), rnd_val(), 1'b0);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tap !== 1 || out_is_q !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset position: valid=%b tap=%0d q=%b want 1 1 1", out_valid, out_tap, out_is_q);
        end
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== 0) begin
            n_fail++;
            $display("FAIL midreset abort: valid=%b ovr=%b data=%0d want 0 0 0", out_valid, overrun, out_data);
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd_val(), rnd_val(), i == 4);
        drain_stream("reset_midstream", 1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int budget = 0;
            coh_len = CW'($urandom_range(0, 2));
            m_done = 1'b0;
            while (!m_done && budget < 300) begin
                code = NT'($urandom);
                cycle(1'($urandom_range(0, 3) != 0), rnd_val(), rnd_val(), $urandom_range(0, 3) == 0);
                budget++;
            end
            n_checks++;
            if (!m_done) begin
                n_fail++;
                $display("FAIL random iter %0d: no completion within %0d cycles", it, budget);
            end else begin
                drain_stream("random", 3);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; dump = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
        mix_i_sign = 1'b0; mix_q_sign = 1'b0; mix_i_mag = '0; mix_q_mag = '0;
        code = '0; coh_len = '0;
        m_cohq = 0; m_done = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_coherent();
        test_overrun();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
